// File: rtl/countdown_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_arbiter: one shared seconds timer granted to three requesters    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module countdown_arbiter #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int DUR0          = 60,
  parameter int DUR1          = 60,
  parameter int DUR2          = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       busy,
  output logic [7:0] remain_sec,
  output logic [2:0] done,
  output logic       abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int            PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    C_DUR0    = 8'(DUR0);
  localparam logic [7:0]    C_DUR1    = 8'(DUR1);
  localparam logic [7:0]    C_DUR2    = 8'(DUR2);

  state_t        state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [7:0]    remain_q, remain_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    done_q, done_d;
  logic          abort_q, abort_d;

  logic w_tick;
  logic w_owner_req;

  assign w_tick      = (presc_q == PRESC_MAX);
  assign w_owner_req = |(req & owner_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    remain_d = remain_q;
    presc_d  = presc_q;
    done_d   = 3'b000;
    abort_d  = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d  = 3'b000;
        busy_d   = 1'b0;
        remain_d = 8'd0;
        presc_d  = '0;
        if (|req) begin
          state_d = RUN;
          busy_d  = 1'b1;
          if (req[2]) begin
            owner_d  = 3'b100;
            remain_d = C_DUR2;
          end else if (req[1]) begin
            owner_d  = 3'b010;
            remain_d = C_DUR1;
          end else begin
            owner_d  = 3'b001;
            remain_d = C_DUR0;
          end
          grant_d = owner_d;
        end
      end

      RUN: begin
        // Losing the owner's request outranks a tick landing on the same edge.
        if (!w_owner_req) begin
          state_d  = IDLE;
          grant_d  = 3'b000;
          busy_d   = 1'b0;
          remain_d = 8'd0;
          presc_d  = '0;
          abort_d  = 1'b1;
        end else if (w_tick) begin
          presc_d = '0;
          if (remain_q > 8'd1) begin
            remain_d = remain_q - 8'd1;
          end else begin
            state_d  = HOLD;
            grant_d  = 3'b000;
            busy_d   = 1'b0;
            remain_d = 8'd0;
            done_d   = owner_q;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      HOLD: begin
        // Stay parked until the expired owner lets go, so it cannot re-grab.
        if (!w_owner_req) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        grant_d  = 3'b000;
        busy_d   = 1'b0;
        remain_d = 8'd0;
        presc_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 3'b000;
      grant_q  <= 3'b000;
      busy_q   <= 1'b0;
      remain_q <= 8'd0;
      presc_q  <= '0;
      done_q   <= 3'b000;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      remain_q <= remain_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign remain_sec = remain_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule
`default_nettype wire
